// File: rtl/paddle_control_if.sv
// Bundles the per-tick control inputs and the paddle state outputs of paddle_control.
interface paddle_control_if;
    logic               tick;
    logic               button_up;
    logic               button_down;
    logic               ai_enable;
    logic signed [10:0] ball_y;
    logic [9:0]         left_paddle_y;
    logic [9:0]         right_paddle_y;
    logic               up_pressed;
    logic               down_pressed;

    modport master (
        output tick, button_up, button_down, ai_enable, ball_y,
        input  left_paddle_y, right_paddle_y, up_pressed, down_pressed
    );

    modport slave (
        input  tick, button_up, button_down, ai_enable, ball_y,
        output left_paddle_y, right_paddle_y, up_pressed, down_pressed
    );
endinterface

// File: rtl/paddle_control.sv
// Player and AI paddle position control: button synchronizing/debouncing,
// tick-driven player movement and speed-limited AI tracking of the ball.
module paddle_control #(
    parameter int TOP_BOUNDARY    = 3,
    parameter int BOTTOM_BOUNDARY = 477,
    parameter int PADDLE_HEIGHT   = 46,
    parameter int BALL_SIZE       = 7,
    parameter int PLAYER_SPEED    = 4,
    parameter int AI_SPEED        = 3,
    parameter int LEFT_START      = 217,
    parameter int RIGHT_START     = 217,
    parameter int DEBOUNCE_COUNT  = 184320
) (
    input logic              clk,
    input logic              reset,
    paddle_control_if.slave  bus
);
    localparam int YMIN  = TOP_BOUNDARY;
    localparam int YMAX  = BOTTOM_BOUNDARY - PADDLE_HEIGHT;
    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);

    localparam logic signed [10:0] P_MIN    = 11'(YMIN);
    localparam logic signed [10:0] P_MAX    = 11'(YMAX);
    localparam logic signed [10:0] P_STEP   = 11'(PLAYER_SPEED);
    localparam logic signed [11:0] A_MIN    = 12'(YMIN);
    localparam logic signed [11:0] A_MAX    = 12'(YMAX);
    localparam logic signed [11:0] A_STEP   = 12'(AI_SPEED);
    localparam logic signed [11:0] A_OFFSET = 12'(BALL_SIZE / 2 - PADDLE_HEIGHT / 2);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            pressed_q;
    logic [1:0][CNT_W-1:0] cnt_q;

    logic [9:0] left_q, left_d;
    logic [9:0] right_q, right_d;

    logic signed [10:0] left_s;
    logic signed [10:0] left_up;
    logic signed [10:0] left_dn;
    logic signed [11:0] ai_target;
    logic signed [11:0] ai_diff;

    // A button change is accepted only after it stays stable for DEBOUNCE_COUNT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            pressed_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q <= {bus.button_down, bus.button_up};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if ((~sync2_q[i]) == pressed_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    pressed_q[i] <= ~pressed_q[i];
                    cnt_q[i]     <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        left_d  = left_q;
        right_d = right_q;

        left_s  = signed'({1'b0, left_q});
        left_up = left_s - P_STEP;
        left_dn = left_s + P_STEP;

        // Signed target so a ball above the screen clamps to the top bound.
        ai_target = signed'({bus.ball_y[10], bus.ball_y}) + A_OFFSET;
        if (ai_target < A_MIN) begin
            ai_target = A_MIN;
        end else if (ai_target > A_MAX) begin
            ai_target = A_MAX;
        end
        ai_diff = ai_target - signed'({2'b00, right_q});

        if (bus.tick) begin
            if (pressed_q == 2'b01) begin
                left_d = (left_up < P_MIN) ? P_MIN[9:0] : left_up[9:0];
            end else if (pressed_q == 2'b10) begin
                left_d = (left_dn > P_MAX) ? P_MAX[9:0] : left_dn[9:0];
            end

            if (bus.ai_enable) begin
                if (ai_diff >= -A_STEP && ai_diff <= A_STEP) begin
                    right_d = ai_target[9:0];
                end else if (ai_diff > 12'sd0) begin
                    right_d = right_q + A_STEP[9:0];
                end else begin
                    right_d = right_q - A_STEP[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_q  <= 10'(LEFT_START);
            right_q <= 10'(RIGHT_START);
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign bus.left_paddle_y  = left_q;
    assign bus.right_paddle_y = right_q;
    assign bus.up_pressed     = pressed_q[0];
    assign bus.down_pressed   = pressed_q[1];
endmodule

// File: tb/tb_paddle_control.sv
// Self-checking bench for paddle_control with a short debounce window.
module tb_paddle_control;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    paddle_control_if bus();

    paddle_control #(.DEBOUNCE_COUNT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] left;
        logic [9:0] right;
        logic       up;
        logic       down;
        string      name;
    } exp_t;

    typedef struct {
        logic               rst;
        logic               tick;
        logic               bup;
        logic               bdn;
        logic               ai;
        logic signed [10:0] ball;
        logic [9:0]         eLeft;
        logic [9:0]         eRight;
        logic               eUp;
        logic               eDown;
        string              name;
    } vec_t;

    exp_t expQ[$];
    vec_t tbl[10];
    int   numChecks = 0;
    int   numFails  = 0;
    int   expL, expR;
    logic expU, expD;

    task automatic cmpField(input string nm, input int act, input int req);
        numChecks++;
        if (act != req) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic tk, input logic bup, input logic bdn,
                                 input logic ai, input logic signed [10:0] ball,
                                 input int eL, input int eR, input logic eU, input logic eD,
                                 input string name);
        exp_t e;
        reset           = rst;
        bus.tick        = tk;
        bus.button_up   = bup;
        bus.button_down = bdn;
        bus.ai_enable   = ai;
        bus.ball_y      = ball;
        e.left  = 10'(eL);
        e.right = 10'(eR);
        e.up    = eU;
        e.down  = eD;
        e.name  = name;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = expQ.pop_front();
        cmpField({e.name, " left"},  int'(bus.left_paddle_y),  int'(e.left));
        cmpField({e.name, " right"}, int'(bus.right_paddle_y), int'(e.right));
        cmpField({e.name, " up"},    int'(bus.up_pressed),     int'(e.up));
        cmpField({e.name, " down"},  int'(bus.down_pressed),   int'(e.down));
    endtask

    task automatic step(input logic tk, input logic bup, input logic bdn, input logic ai,
                        input logic signed [10:0] ball, input string name);
        applyStimulus(1'b0, tk, bup, bdn, ai, ball, expL, expR, expU, expD, name);
        checkOutput();
    endtask

    function automatic int aiNext(input int y, input int ball);
        int t, d;
        t = ball + 3 - 23;
        if (t < 3)   t = 3;
        if (t > 431) t = 431;
        d = t - y;
        if (d >= -3 && d <= 3) return t;
        return (d > 0) ? y + 3 : y - 3;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'sd0,   10'd217, 10'd217, 1'b0, 1'b0, "reset_with_tick"};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'sd0,   10'd217, 10'd217, 1'b0, 1'b0, "idle_after_reset"};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd230, 10'd217, 10'd214, 1'b0, 1'b0, "ai_full_step_up"};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd233, 10'd217, 10'd213, 1'b0, 1'b0, "ai_partial_step"};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd240, 10'd217, 10'd216, 1'b0, 1'b0, "ai_full_step_down"};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'sd0,   10'd217, 10'd216, 1'b0, 1'b0, "no_tick_hold"};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'sd0,   10'd217, 10'd216, 1'b0, 1'b0, "ai_disabled_hold"};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd218, 10'd217, 10'd213, 1'b0, 1'b0, "ai_step_up_again"};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'sd0,   10'd217, 10'd217, 1'b0, 1'b0, "reset_again"};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'sd237, 10'd217, 10'd217, 1'b0, 1'b0, "ai_on_target"};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].tick, tbl[i].bup, tbl[i].bdn, tbl[i].ai, tbl[i].ball,
                          int'(tbl[i].eLeft), int'(tbl[i].eRight), tbl[i].eUp, tbl[i].eDown, tbl[i].name);
            checkOutput();
        end

        expL = 217; expR = 217; expU = 1'b0; expD = 1'b0;

        // Short glitch must not get through; then a clean press after 2+4 cycles.
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 11'sd0, "glitch_low");
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 11'sd0, "glitch_high");
        for (int k = 1; k <= 10; k++) begin
            expU = (k >= 6);
            step(1'b0, 1'b0, 1'b1, 1'b0, 11'sd0, $sformatf("press_up_%0d", k));
        end

        step(1'b0, 1'b0, 1'b1, 1'b0, 11'sd0, "up_no_tick");
        for (int k = 1; k <= 5; k++) begin
            expL = expL - 4;
            step(1'b1, 1'b0, 1'b1, 1'b0, 11'sd0, "up_tick");
        end

        for (int k = 1; k <= 8; k++) begin
            expD = (k >= 6);
            step(1'b0, 1'b0, 1'b0, 1'b0, 11'sd0, "press_down");
        end
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 11'sd0, "both_pressed_hold");
        for (int k = 1; k <= 8; k++) begin
            expD = (k < 6);
            step(1'b0, 1'b0, 1'b1, 1'b0, 11'sd0, "release_down");
        end

        for (int k = 1; k <= 55; k++) begin
            expL = (expL - 4 < 3) ? 3 : expL - 4;
            step(1'b1, 1'b0, 1'b1, 1'b0, 11'sd0, "up_sweep");
        end
        cmpField("left_top_clamp", int'(bus.left_paddle_y), 3);

        for (int k = 1; k <= 8; k++) begin
            expU = (k < 6);
            step(1'b0, 1'b1, 1'b1, 1'b0, 11'sd0, "release_up");
        end
        for (int k = 1; k <= 8; k++) begin
            expD = (k >= 6);
            step(1'b0, 1'b1, 1'b0, 1'b0, 11'sd0, "press_down_again");
        end
        for (int k = 1; k <= 200; k++) begin
            expL = (expL + 4 > 431) ? 431 : expL + 4;
            step(1'b1, 1'b1, 1'b0, 1'b0, 11'sd0, "down_sweep");
        end
        cmpField("left_bottom_clamp", int'(bus.left_paddle_y), 431);

        for (int k = 1; k <= 50; k++) begin
            expR = aiNext(expR, 100);
            step(1'b1, 1'b1, 1'b0, 1'b1, 11'sd100, "ai_track_100");
        end
        cmpField("ai_lands_80", int'(bus.right_paddle_y), 80);
        for (int k = 1; k <= 30; k++) begin
            expR = aiNext(expR, -5);
            step(1'b1, 1'b1, 1'b0, 1'b1, -11'sd5, "ai_track_neg");
        end
        cmpField("ai_top_clamp", int'(bus.right_paddle_y), 3);
        for (int k = 1; k <= 150; k++) begin
            expR = aiNext(expR, 470);
            step(1'b1, 1'b1, 1'b0, 1'b1, 11'sd470, "ai_track_470");
        end
        cmpField("ai_bottom_clamp", int'(bus.right_paddle_y), 431);

        for (int k = 1; k <= 10; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 11'sd0, "ai_disabled_sweep");
        for (int k = 1; k <= 5; k++) begin
            expR = aiNext(expR, 0);
            step(1'b1, 1'b1, 1'b0, 1'b1, 11'sd0, "ai_sweep_before_reset");
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 11'sd0, 217, 217, 1'b0, 1'b0, "reset_mid_sweep");
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'sd0, 217, 217, 1'b0, 1'b0, "idle_end");
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule

// File: doc/paddle_control.md
Name: paddle_control

Overview:
- Upstream stage of the ball collision and display logic.
- Produces the left (player) and right (AI) paddle top-edge Y positions that the ball and display blocks consume.
- The player paddle is driven by two debounced, active-low push buttons.
- The AI paddle tracks the ball's vertical centre with a per-step speed limit.
- Positions advance only on a movement tick, so game speed stays independent of the clock.

Parameters:
- TOP_BOUNDARY, 3: smallest legal paddle top Y.
- BOTTOM_BOUNDARY, 477: playfield bottom edge. Paddle bottom (y+PADDLE_HEIGHT) never exceeds it.
- PADDLE_HEIGHT, 46: paddle height in pixels.
- BALL_SIZE, 7: ball edge length in pixels, used for the AI centre target.
- PLAYER_SPEED, 4: pixels moved per tick by the player paddle.
- AI_SPEED, 3: maximum pixels moved per tick by the AI paddle.
- LEFT_START, 217: reset Y of the left paddle.
- RIGHT_START, 217: reset Y of the right paddle.
- DEBOUNCE_COUNT, 184320: consecutive stable cycles required to accept a button change (about 10 ms at pixel_clk).

Ports:
- clk, input, 1: pixel clock. All state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: single-cycle movement strobe, one per game step.
- button_up, input, 1: raw asynchronous up button, active-low.
- button_down, input, 1: raw asynchronous down button, active-low.
- ai_enable, input, 1: when low, the AI paddle holds its position.
- ball_y, input, 11: signed ball top-edge Y.
- left_paddle_y, output, 10: player paddle top Y, registered.
- right_paddle_y, output, 10: AI paddle top Y, registered.
- up_pressed, output, 1: debounced up state, active-high.
- down_pressed, output, 1: debounced down state, active-high.

Behaviour:
- Reset (synchronous, wins over everything):
  - left_paddle_y = LEFT_START, right_paddle_y = RIGHT_START.
  - up_pressed and down_pressed = 0.
  - Debounce counters = 0.
  - Synchronizer flops = 1 (released).
  - A tick in the same cycle as reset is ignored.
- Derived limits:
  - YMIN = TOP_BOUNDARY.
  - YMAX = BOTTOM_BOUNDARY - PADDLE_HEIGHT = 431 at defaults.
  - Both outputs stay within [YMIN, YMAX] at all times.
- Input synchronization: each button passes through a 2-flop synchronizer before debouncing.
- Debounce, per button (independent counters):
  - Counter width: ceil(log2(DEBOUNCE_COUNT+1)).
  - If the synced level (inverted) equals the current debounced state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_COUNT-1 and the input still differs, the debounced state toggles on that edge and the counter clears.
  - Any bounce back clears the counter, so the count restarts.
  - Latency from a clean button edge to the debounced change: 2 + DEBOUNCE_COUNT cycles.
- Player paddle, evaluated only on clk edges with tick=1:
  - up_pressed only: y <= max(y - PLAYER_SPEED, YMIN).
  - down_pressed only: y <= min(y + PLAYER_SPEED, YMAX).
  - Both or neither pressed: hold.
  - Arithmetic is 11-bit signed so the subtraction cannot wrap below 0.
- AI paddle, evaluated only with tick=1 and ai_enable=1:
  - target = ball_y + BALL_SIZE/2 - PADDLE_HEIGHT/2, with integer division (= ball_y - 20 at defaults).
  - target is computed signed and then clamped to [YMIN, YMAX]; a negative ball_y therefore clamps to YMIN.
  - diff = target - y.
  - If |diff| <= AI_SPEED: y <= target.
  - Otherwise y moves AI_SPEED toward target.
  - ai_enable=0: hold.
- Timing: outputs change on the same edge that samples tick=1, so new values are visible the cycle after the tick is asserted.
- No combinational path from any input to any output.
- Long-held buttons: a sustained press keeps moving the player paddle every tick and saturates at the bound; there is no overflow.

Test Plan:
- Reset: bench uses DEBOUNCE_COUNT=4. Assert reset with tick=1 and button_up low → left=217, right=217, up_pressed=0 one cycle later; no movement.
- Debounce: drive button_up low for 3 cycles, then high, then low for 10 cycles →
  - up_pressed stays 0 through the 3-cycle glitch;
  - up_pressed rises exactly 6 cycles after the final falling edge.
- Player movement and clamp: hold up, 60 ticks → left goes 217, 213, … , reaches 5 after 53 ticks, then clamps at 3 and holds. Hold down, 200 ticks → saturates at 431.
- Both buttons pressed with tick → left unchanged. Tick=0 with up pressed → no change.
- AI tracking, ai_enable=1: ball_y=100, right=217 → target 80; right steps 214, 211, … and lands exactly on 80 with a final partial step. Then ball_y=-5 → target clamps to 3. Then ball_y=470 → target clamps to 431.
- ai_enable=0 with ball_y=0 over 10 ticks → right unchanged. Reset asserted mid-sweep → right returns to 217 on the next edge.
